// File: rtl/wave_rom_player.sv
`default_nettype none
// ============================================================================
// Module   : wave_rom_player
// Brief    : Phase-accumulator reader for a single-port waveform ROM that
//            returns latency-aligned, amplitude-scaled samples to the DAC path.
// Revision : 1.0 - initial release
// ============================================================================
module wave_rom_player #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int ROM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PHASE_WIDTH-1:0] freq_word,
  input  logic [ADDR_WIDTH-1:0]  phase_offset,
  input  logic [2:0]             amp_shift,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic [DATA_WIDTH-1:0]  dac_data,
  output logic                   dac_valid,
  output logic                   busy,
  output logic                   wrap
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  localparam int CNT_W = $clog2(ROM_LATENCY + 1) + 1;
  localparam logic [CNT_W-1:0]      c_DRAIN_LAST = CNT_W'(ROM_LATENCY);
  localparam logic [DATA_WIDTH-1:0] c_MIDSCALE   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]             r_state;
  logic [PHASE_WIDTH-1:0] r_acc;
  logic [PHASE_WIDTH-1:0] r_fw;
  logic [ADDR_WIDTH-1:0]  r_offset;
  logic [2:0]             r_shift;
  logic [CNT_W-1:0]       r_drain_cnt;
  logic [ROM_LATENCY:0]   r_tok;

  logic                          w_issue;
  logic                          w_drain_done;
  logic                          w_carry;
  logic [PHASE_WIDTH-1:0]        w_acc_next;
  logic [ADDR_WIDTH-1:0]         w_addr_next;
  logic signed [DATA_WIDTH:0]    w_centered;
  logic signed [DATA_WIDTH:0]    w_shifted;
  logic [DATA_WIDTH-1:0]         w_scaled;

  assign w_issue      = (r_state == c_ST_RUN) && !stop;
  assign w_drain_done = (r_state == c_ST_DRAIN) && (r_drain_cnt == c_DRAIN_LAST);

  assign {w_carry, w_acc_next} = {1'b0, r_acc} + {1'b0, r_fw};
  // Address uses the pre-increment phase so the first issued address is the offset.
  assign w_addr_next = r_acc[PHASE_WIDTH-1 -: ADDR_WIDTH] + r_offset;

  // Attenuate about midscale; the result always lands back inside DATA_WIDTH bits.
  assign w_centered = $signed({1'b0, rom_data}) - $signed({1'b0, c_MIDSCALE});
  assign w_shifted  = w_centered >>> r_shift;
  assign w_scaled   = w_shifted[DATA_WIDTH-1:0] + c_MIDSCALE;

  assign busy = (r_state != c_ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_acc       <= '0;
      r_fw        <= '0;
      r_offset    <= '0;
      r_shift     <= '0;
      r_drain_cnt <= '0;
      rom_addr    <= '0;
      wrap        <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          wrap <= 1'b0;
          if (start) begin
            r_fw     <= freq_word;
            r_offset <= phase_offset;
            r_shift  <= amp_shift;
            r_acc    <= '0;
            r_state  <= c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          if (stop) begin
            wrap        <= 1'b0;
            r_drain_cnt <= '0;
            r_state     <= c_ST_DRAIN;
          end else begin
            r_acc    <= w_acc_next;
            rom_addr <= w_addr_next;
            wrap     <= w_carry;
          end
        end
        c_ST_DRAIN: begin
          wrap <= 1'b0;
          if (w_drain_done) begin
            r_state <= c_ST_IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: begin
          wrap    <= 1'b0;
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Valid tokens ride alongside the ROM read so data and flag stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tok     <= '0;
      dac_valid <= 1'b0;
      dac_data  <= c_MIDSCALE;
    end else begin
      if (w_drain_done) begin
        r_tok     <= '0;
        dac_valid <= 1'b0;
        dac_data  <= c_MIDSCALE;
      end else begin
        r_tok <= {r_tok[ROM_LATENCY-1:0], w_issue};
        if (r_tok[ROM_LATENCY]) begin
          dac_valid <= 1'b1;
          dac_data  <= w_scaled;
        end else begin
          dac_valid <= 1'b0;
          dac_data  <= c_MIDSCALE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wave_rom_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_rom_player
// Brief    : Directed bench for wave_rom_player at ROM latency 1 and 2, with a
//            sample scoreboard fed from a closed-form phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_rom_player;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]          start, stop;
  logic [PW-1:0]       freq_word;
  logic [AW-1:0]       phase_offset;
  logic [2:0]          amp_shift;
  logic [1:0][AW-1:0]  rom_addr;
  logic [1:0][DW-1:0]  rom_data;
  logic [1:0][DW-1:0]  dac_data;
  logic [1:0]          dac_valid, busy, wrap;

  wave_rom_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ROM_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]), .freq_word(freq_word),
    .phase_offset(phase_offset), .amp_shift(amp_shift), .rom_addr(rom_addr[0]),
    .rom_data(rom_data[0]), .dac_data(dac_data[0]), .dac_valid(dac_valid[0]),
    .busy(busy[0]), .wrap(wrap[0]));

  wave_rom_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ROM_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]), .freq_word(freq_word),
    .phase_offset(phase_offset), .amp_shift(amp_shift), .rom_addr(rom_addr[1]),
    .rom_data(rom_data[1]), .dac_data(dac_data[1]), .dac_valid(dac_valid[1]),
    .busy(busy[1]), .wrap(wrap[1]));

  // Square table ROMs: one synchronous read stage, plus an output register for latency 2.
  logic [DW-1:0] rom_img [1024];
  logic [DW-1:0] rom_q0, rom_q1a, rom_q1b;
  initial for (int i = 0; i < 1024; i++) rom_img[i] = (i < 512) ? 8'hFF : 8'h00;
  always @(posedge clk) begin
    rom_q0  <= rom_img[rom_addr[0]];
    rom_q1a <= rom_img[rom_addr[1]];
    rom_q1b <= rom_q1a;
  end
  assign rom_data[0] = rom_q0;
  assign rom_data[1] = rom_q1b;

  int n_checks = 0;
  int n_fails  = 0;

  bit            m_run  [2];
  bit            m_pend [2];
  bit            m_seen [2];
  logic [PW-1:0] m_acc  [2];
  logic [PW-1:0] m_fw   [2];
  logic [AW-1:0] m_off  [2];
  logic [AW-1:0] m_last [2];
  logic [2:0]    m_sh   [2];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            valid_cnt [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] v, input logic [2:0] sh);
    int s;
    s = int'(v) - 128;
    s = s >>> sh;
    return 8'(s + 128);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_pend[d] = 0; m_seen[d] = 0;
      m_acc[d] = '0; m_fw[d] = '0; m_off[d] = '0; m_last[d] = '0; m_sh[d] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock: predict issued address and wrap, push expected sample, pop on dac_valid.
  task automatic tick();
    bit            pre_run  [2];
    logic [AW-1:0] exp_addr [2];
    logic [PW:0]   sum      [2];
    logic [DW-1:0] e;
    for (int d = 0; d < 2; d++) begin
      pre_run[d]  = m_run[d];
      exp_addr[d] = m_acc[d][PW-1 -: AW] + m_off[d];
      sum[d]      = {1'b0, m_acc[d]} + {1'b0, m_fw[d]};
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (pre_run[d] && stop[d]) begin
        m_run[d] = 0;
        check("addr_freeze", 32'(rom_addr[d]), 32'(m_last[d]));
        check("wrap_at_stop", 32'(wrap[d]), 0);
      end else if (pre_run[d]) begin
        check("rom_addr", 32'(rom_addr[d]), 32'(exp_addr[d]));
        check("wrap", 32'(wrap[d]), 32'(sum[d][PW]));
        if (d == 0) q0.push_back(scale(rom_img[exp_addr[d]], m_sh[d]));
        else        q1.push_back(scale(rom_img[exp_addr[d]], m_sh[d]));
        m_acc[d]  = sum[d][PW-1:0];
        m_last[d] = exp_addr[d];
      end else begin
        check("wrap_idle", 32'(wrap[d]), 0);
        if (m_pend[d]) begin
          m_run[d] = 1; m_acc[d] = '0; m_seen[d] = 0;
          m_fw[d] = freq_word; m_off[d] = phase_offset; m_sh[d] = amp_shift;
        end
      end
      m_pend[d] = 0;
      if (m_seen[d] && m_run[d]) check("valid_gap", 32'(dac_valid[d]), 1);
      if (dac_valid[d]) begin
        valid_cnt[d]++;
        m_seen[d] = 1;
        if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check("dac_data", 32'(dac_data[d]), 32'(e));
        end
      end
    end
  endtask

  task automatic do_start(input int d);
    start[d] = 1'b1;
    m_pend[d] = 1;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic end_run(input int d);
    stop[d] = 1'b1;
    tick();
    stop[d] = 1'b0;
    repeat (4) tick();
    check("sb_empty", (d == 0) ? q0.size() : q1.size(), 0);
    check("idle_valid", 32'(dac_valid[d]), 0);
    check("idle_data", 32'(dac_data[d]), 32'h80);
    check("idle_busy", 32'(busy[d]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int after_stop;
    rst = 1'b1; start = '0; stop = '0;
    freq_word = '0; phase_offset = '0; amp_shift = '0;
    valid_cnt[0] = 0; valid_cnt[1] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_addr", 32'(rom_addr[d]), 0);
      check("rst_data", 32'(dac_data[d]), 32'h80);
      check("rst_valid", 32'(dac_valid[d]), 0);
      check("rst_busy", 32'(busy[d]), 0);
      check("rst_wrap", 32'(wrap[d]), 0);
    end
    #2 rst = 1'b0;
    tick();

    // Square, step 1, no attenuation, latency 1.
    freq_word = 32'h0040_0000; phase_offset = '0; amp_shift = 3'd0;
    do_start(0);
    check("busy_run", 32'(busy[0]), 1);
    tick(); check("first_addr", 32'(rom_addr[0]), 0); check("valid_e1", 32'(dac_valid[0]), 0);
    tick(); check("valid_e2", 32'(dac_valid[0]), 0);
    tick(); check("valid_e3", 32'(dac_valid[0]), 1); check("first_sample", 32'(dac_data[0]), 32'hFF);
    freq_word = 32'h1234_5678; phase_offset = 10'd5; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wc = 0;
    for (int i = 0; i < 2096; i++) begin
      tick();
      if (wrap[0]) wc++;
    end
    check("wrap_count", wc, 2);
    end_run(0);

    // Attenuated by 2 and by 128.
    freq_word = 32'h0040_0000; phase_offset = '0; amp_shift = 3'd1;
    do_start(0);
    repeat (3) tick(); check("shift1_hi", 32'(dac_data[0]), 32'hBF);
    repeat (512) tick(); check("shift1_lo", 32'(dac_data[0]), 32'h40);
    end_run(0);
    amp_shift = 3'd7;
    do_start(0);
    repeat (3) tick(); check("shift7_hi", 32'(dac_data[0]), 32'h80);
    repeat (512) tick(); check("shift7_lo", 32'(dac_data[0]), 32'h7F);
    end_run(0);

    // Step 2 from the top address: seamless wrap through 0.
    freq_word = 32'h0080_0000; phase_offset = 10'h3FF; amp_shift = 3'd0;
    do_start(0);
    tick(); check("wrap_addr0", 32'(rom_addr[0]), 32'h3FF);
    tick(); check("wrap_addr1", 32'(rom_addr[0]), 32'h001);
    tick(); check("wrap_addr2", 32'(rom_addr[0]), 32'h003);
    repeat (600) tick();
    end_run(0);

    // Latency 2: first valid at edge 4, stop at edge 100 held three cycles, start during drain.
    freq_word = 32'h0040_0000; phase_offset = '0; amp_shift = 3'd0;
    do_start(1);
    repeat (3) tick(); check("l2_valid_e3", 32'(dac_valid[1]), 0);
    tick(); check("l2_valid_e4", 32'(dac_valid[1]), 1);
    repeat (95) tick();
    check("l2_addr_e99", 32'(rom_addr[1]), 32'd98);
    stop[1] = 1'b1;
    after_stop = 0;
    tick(); if (dac_valid[1]) after_stop++;
    start[1] = 1'b1;
    tick(); if (dac_valid[1]) after_stop++;
    start[1] = 1'b0;
    tick(); if (dac_valid[1]) after_stop++;
    stop[1] = 1'b0;
    tick(); if (dac_valid[1]) after_stop++;
    check("drain_samples", after_stop, 3);
    check("drain_valid", 32'(dac_valid[1]), 0);
    check("drain_data", 32'(dac_data[1]), 32'h80);
    check("drain_busy", 32'(busy[1]), 0);
    check("drain_sb_empty", q1.size(), 0);
    repeat (4) tick();
    check("drain_start_ignored", 32'(busy[1]), 0);
    check("drain_addr_frozen", 32'(rom_addr[1]), 32'd98);

    // fw = 0, offset 600, start and stop together from IDLE.
    freq_word = '0; phase_offset = 10'd600; amp_shift = 3'd0;
    start[0] = 1'b1; stop[0] = 1'b1; m_pend[0] = 1;
    tick();
    start[0] = 1'b0; stop[0] = 1'b0;
    check("start_wins", 32'(busy[0]), 1);
    repeat (40) tick();
    check("const_addr", 32'(rom_addr[0]), 32'd600);
    check("const_valid", 32'(dac_valid[0]), 1);
    check("const_data", 32'(dac_data[0]), 32'h00);
    end_run(0);

    // Asynchronous reset while running at address 0x155.
    freq_word = 32'h0040_0000; phase_offset = '0;
    do_start(0);
    repeat (32'h156) tick();
    check("pre_reset_addr", 32'(rom_addr[0]), 32'h155);
    #2 rst = 1'b1;
    #1;
    check("arst_addr", 32'(rom_addr[0]), 0);
    check("arst_data", 32'(dac_data[0]), 32'h80);
    check("arst_valid", 32'(dac_valid[0]), 0);
    check("arst_busy", 32'(busy[0]), 0);
    model_reset();
    #3 rst = 1'b0;
    repeat (3) tick();
    check("post_reset_busy", 32'(busy[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
